fft_pingpong_ram: RTL and testbench

Two-bank complex-sample ping-pong memory for the iterative FFT core. One bank is the read bank and the other is the write bank, so a butterfly stage can read operands from one bank while writing results into the other. A single-cycle swap request exchanges the two roles.

---
 rtl/fft_pingpong_ram.sv | 114 +++++++++++
 tb/tb_fft_pingpong_ram.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong store for the iterative FFT. One bank is read while the
// other is written, and a one-cycle swap exchanges the two roles.
module fft_pingpong_ram #(
  parameter int DWL        = 16,
  parameter int AWL        = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           i_SWAP,
  input  logic           i_BITREV,
  input  logic           i_WrE,
  input  logic [AWL-1:0] i_WR_ADDR,
  input  logic [DWL-1:0] i_WR_RE,
  input  logic [DWL-1:0] i_WR_IM,
  input  logic           i_RdE,
  input  logic [AWL-1:0] i_RD_ADDR,
  output logic [DWL-1:0] o_RD_RE,
  output logic [DWL-1:0] o_RD_IM,
  output logic           o_RD_VALID,
  output logic           o_BANK,
  output logic [AWL:0]   o_WR_CNT,
  output logic           o_FULL
);
  localparam int           DEPTH   = 1 << AWL;
  localparam logic [AWL:0] CNT_MAX = (AWL+1)'(DEPTH);

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
      $error("fft_pingpong_ram: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  logic                 r_bank;
  logic [AWL:0]         r_wr_cnt;
  logic                 r_full;
  logic [2*DWL-1:0]     r_mem0 [DEPTH];
  logic [2*DWL-1:0]     r_mem1 [DEPTH];
  logic [AWL-1:0]       w_rev_addr;
  logic [AWL-1:0]       w_wr_addr;
  logic [2*DWL-1:0]     w_rd_data;
  logic                 r_vld1;
  logic [2*DWL-1:0]     r_dat1;
  logic                 w_out_vld;
  logic [2*DWL-1:0]     w_out_dat;

  for (genvar i = 0; i < AWL; i++) begin : g_rev
    assign w_rev_addr[i] = i_WR_ADDR[AWL-1-i];
  end
  assign w_wr_addr = i_BITREV ? w_rev_addr : i_WR_ADDR;

  // Storage is deliberately outside the reset domain so contents survive RST.
  always_ff @(posedge CLK) begin
    if (i_WrE && r_bank)  r_mem0[w_wr_addr] <= {i_WR_RE, i_WR_IM};
    if (i_WrE && !r_bank) r_mem1[w_wr_addr] <= {i_WR_RE, i_WR_IM};
  end

  assign w_rd_data = r_bank ? r_mem1[i_RD_ADDR] : r_mem0[i_RD_ADDR];

  // A write coincident with a swap lands in the old bank but is not counted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bank   <= 1'b0;
      r_wr_cnt <= '0;
      r_full   <= 1'b0;
    end else if (i_SWAP) begin
      r_bank   <= ~r_bank;
      r_wr_cnt <= '0;
      r_full   <= 1'b0;
    end else if (i_WrE && !r_full) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      r_full   <= (r_wr_cnt == CNT_MAX - 1'b1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_vld1 <= 1'b0;
      r_dat1 <= '0;
    end else begin
      r_vld1 <= i_RdE;
      if (i_RdE) r_dat1 <= w_rd_data;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic             r_vld2;
      logic [2*DWL-1:0] r_dat2;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_vld2 <= 1'b0;
          r_dat2 <= '0;
        end else begin
          r_vld2 <= r_vld1;
          if (r_vld1) r_dat2 <= r_dat1;
        end
      end
      assign w_out_vld = r_vld2;
      assign w_out_dat = r_dat2;
    end else begin : g_lat1
      assign w_out_vld = r_vld1;
      assign w_out_dat = r_dat1;
    end
  endgenerate

  assign o_RD_VALID = w_out_vld;
  assign o_RD_RE    = w_out_dat[2*DWL-1:DWL];
  assign o_RD_IM    = w_out_dat[DWL-1:0];
  assign o_BANK     = r_bank;
  assign o_WR_CNT   = r_wr_cnt;
  assign o_FULL     = r_full;

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Bench for fft_pingpong_ram: latency-1 and latency-2 instances share stimulus
// and are compared against a bank/array model with a per-edge read history.
module tb_fft_pingpong_ram;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        sw = 1'b0, br = 1'b0, we = 1'b0, re = 1'b0;
  logic [2:0]  wa = '0, ra = '0;
  logic [15:0] wre = '0, wim = '0;
  logic [15:0] re1, im1, re2, im2;
  logic        v1, v2, bank1, bank2, full1, full2;
  logic [3:0]  cnt1, cnt2;

  always #5 CLK = ~CLK;

  fft_pingpong_ram #(.DWL(16), .AWL(3), .RD_LATENCY(1)) u1 (
    .CLK(CLK), .RST(RST), .i_SWAP(sw), .i_BITREV(br), .i_WrE(we), .i_WR_ADDR(wa),
    .i_WR_RE(wre), .i_WR_IM(wim), .i_RdE(re), .i_RD_ADDR(ra), .o_RD_RE(re1),
    .o_RD_IM(im1), .o_RD_VALID(v1), .o_BANK(bank1), .o_WR_CNT(cnt1), .o_FULL(full1));
  fft_pingpong_ram #(.DWL(16), .AWL(3), .RD_LATENCY(2)) u2 (
    .CLK(CLK), .RST(RST), .i_SWAP(sw), .i_BITREV(br), .i_WrE(we), .i_WR_ADDR(wa),
    .i_WR_RE(wre), .i_WR_IM(wim), .i_RdE(re), .i_RD_ADDR(ra), .o_RD_RE(re2),
    .o_RD_IM(im2), .o_RD_VALID(v2), .o_BANK(bank2), .o_WR_CNT(cnt2), .o_FULL(full2));

  // Reference model: two plain arrays, a read-bank index and a write count.
  logic [31:0] m_mem [2][8];
  int          m_bank, m_cnt, e;
  bit          hist_v [4096];
  logic [31:0] hist_d [4096];
  logic [32:0] exp_r1, exp_r2;
  logic [5:0]  exp_st;
  int          checks = 0, errors = 0;

  function automatic logic [2:0] brev(input logic [2:0] a);
    return {a[0], a[1], a[2]};
  endfunction

  task automatic model_reset();
    m_bank = 0; m_cnt = 0; hist_v[e] = 0;
    exp_r1 = '0; exp_r2 = '0; exp_st = '0;
  endtask

  task automatic tick(input bit s, input bit b, input bit w, input logic [2:0] wad,
                      input logic [15:0] dr, input logic [15:0] di,
                      input bit r, input logic [2:0] rad);
    sw = s; br = b; we = w; wa = wad; wre = dr; wim = di; re = r; ra = rad;
    @(posedge CLK);
    e++;
    hist_v[e] = r;
    if (r) hist_d[e] = m_mem[m_bank][rad];
    if (w) m_mem[1-m_bank][b ? brev(wad) : wad] = {dr, di};
    if (s) begin m_cnt = 0; m_bank = 1 - m_bank; end
    else if (w && m_cnt < 8) m_cnt++;
    if (hist_v[e]) exp_r1 = {1'b1, hist_d[e]}; else exp_r1[32] = 1'b0;
    if (hist_v[e-1]) exp_r2 = {1'b1, hist_d[e-1]}; else exp_r2[32] = 1'b0;
    exp_st = {m_bank[0], 4'(m_cnt), m_cnt == 8};
    #1;
  endtask

  task automatic test_reset();
    for (int b = 0; b < 2; b++) for (int a = 0; a < 8; a++) m_mem[b][a] = '0;
    e = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({v1, re1, im1, v2, re2, im2} !== '0) begin
      errors++; $display("FAIL reset_rd got %h %h %h %h exp 0", v1, re1, v2, re2);
    end
    checks++;
    if ({bank1, cnt1, full1, bank2, cnt2, full2} !== '0) begin
      errors++; $display("FAIL reset_state got %b %h %b exp 0", bank1, cnt1, full1);
    end
    RST = 1'b0;
  endtask

  task automatic test_fill_read();
    for (int k = 0; k < 8; k++) begin
      tick(0, 0, 1, 3'(k), 16'(k), 16'(~k), 0, 0);
      checks++;
      if (cnt1 !== 4'(k+1) || full1 !== (k == 7) || cnt2 !== 4'(k+1)) begin
        errors++; $display("FAIL fill_cnt got %0d/%b exp %0d/%b", cnt1, full1, k+1, k == 7);
      end
    end
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({bank1, cnt1, full1} !== {1'b1, 4'd0, 1'b0}) begin
      errors++; $display("FAIL fill_swap got %b/%0d/%b exp 1/0/0", bank1, cnt1, full1);
    end
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, 0, 0, 0, 0, k < 8, 3'(k));
      checks++;
      if (k < 8 && (v1 !== 1'b1 || re1 !== 16'(k) || im1 !== 16'(~k))) begin
        errors++; $display("FAIL fill_rd1 k=%0d got %b/%h/%h exp 1/%h", k, v1, re1, im1, 16'(k));
      end
      checks++;
      if ({v2, re2, im2} !== exp_r2 || {v1, re1, im1} !== exp_r1) begin
        errors++; $display("FAIL fill_rd_model got %h %h exp %h %h", {v1, re1, im1}, {v2, re2, im2}, exp_r1, exp_r2);
      end
    end
  endtask

  task automatic test_bitrev();
    for (int k = 0; k < 8; k++) tick(0, 1, 1, 3'(k), 16'(k), 16'(k + 100), 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 3'd1);
    checks++;
    if (v1 !== 1'b1 || re1 !== 16'd4) begin
      errors++; $display("FAIL bitrev_a1 got %b/%0d exp 1/4", v1, re1);
    end
    tick(0, 0, 0, 0, 0, 0, 1, 3'd6);
    checks++;
    if (v1 !== 1'b1 || re1 !== 16'd3 || v2 !== 1'b1 || re2 !== 16'd4) begin
      errors++; $display("FAIL bitrev_a6 got %b/%0d %b/%0d exp 1/3 1/4", v1, re1, v2, re2);
    end
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (v2 !== 1'b1 || re2 !== 16'd3 || {v1, re1, im1} !== exp_r1) begin
      errors++; $display("FAIL bitrev_tail got %b/%0d %h exp 1/3 %h", v2, re2, {v1, re1, im1}, exp_r1);
    end
  endtask

  task automatic test_lat2();
    logic [2:0] a;
    a = 3'($urandom);
    tick(0, 0, 0, 0, 0, 0, 1, a);
    checks++;
    if (v2 !== 1'b0 || v1 !== 1'b1 || {re1, im1} !== m_mem[m_bank][a]) begin
      errors++; $display("FAIL lat2_c1 got v2=%b v1=%b d1=%h exp 0 1 %h", v2, v1, {re1, im1}, m_mem[m_bank][a]);
    end
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (v2 !== 1'b1 || {re2, im2} !== m_mem[m_bank][a] || v1 !== 1'b0) begin
      errors++; $display("FAIL lat2_c2 got v2=%b d2=%h v1=%b exp 1 %h 0", v2, {re2, im2}, v1, m_mem[m_bank][a]);
    end
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (v2 !== 1'b0 || {re2, im2} !== m_mem[m_bank][a]) begin
      errors++; $display("FAIL lat2_hold got v2=%b d2=%h exp 0 %h", v2, {re2, im2}, m_mem[m_bank][a]);
    end
  endtask

  task automatic test_swap_collision();
    logic [2:0] a, r;
    logic [15:0] dr, di;
    logic        old_bank;
    a = 3'($urandom); r = 3'($urandom); dr = 16'($urandom); di = 16'($urandom);
    old_bank = bank1;
    tick(0, 0, 1, 3'(a + 3'd1), 16'($urandom), 16'($urandom), 0, 0);
    tick(1, 0, 1, a, dr, di, 1, r);
    checks++;
    if (cnt1 !== 4'd0 || cnt2 !== 4'd0 || bank1 !== ~old_bank || {v1, re1, im1} !== exp_r1) begin
      errors++; $display("FAIL swap_col got cnt=%0d bank=%b d=%h exp 0 %b %h", cnt1, bank1, {v1, re1, im1}, ~old_bank, exp_r1);
    end
    tick(0, 0, 0, 0, 0, 0, 1, a);
    checks++;
    if (v1 !== 1'b1 || {re1, im1} !== {dr, di} || {v2, re2, im2} !== exp_r2) begin
      errors++; $display("FAIL swap_wr got %h exp %h", {re1, im1}, {dr, di});
    end
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({v2, re2, im2} !== {1'b1, dr, di}) begin
      errors++; $display("FAIL swap_wr2 got %h exp %h", {v2, re2, im2}, {1'b1, dr, di});
    end
  endtask

  task automatic test_reset_inflight();
    tick(0, 0, 0, 0, 0, 0, 1, 3'd2);
    tick(0, 0, 0, 0, 0, 0, 1, 3'd5);
    re = 1'b0;
    RST = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({v1, re1, im1, v2, re2, im2, bank1, cnt1, full1, bank2} !== '0) begin
      errors++; $display("FAIL rst_async got %b %h %b %h bank=%b cnt=%0d exp 0", v1, re1, v2, re2, bank1, cnt1);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({v1, re1, im1, v2, re2, im2, bank1, bank2} !== '0) begin
        errors++; $display("FAIL rst_novalid k=%0d got %b %h %b %h exp 0", k, v1, re1, v2, re2);
      end
    end
    for (int k = 0; k < 9; k++) begin
      tick(0, 0, 0, 0, 0, 0, k < 8, 3'(k));
      checks++;
      if ({v1, re1, im1} !== exp_r1 || {v2, re2, im2} !== exp_r2) begin
        errors++; $display("FAIL rst_keep k=%0d got %h %h exp %h %h", k, {v1, re1, im1}, {v2, re2, im2}, exp_r1, exp_r2);
      end
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 8; k++) tick(0, 0, 1, 3'(k), 16'($urandom), 16'($urandom), 0, 0);
    tick(0, 0, 1, 3'd5, 16'hA5A5, 16'h5A5A, 0, 0);
    checks++;
    if (cnt1 !== 4'd8 || full1 !== 1'b1 || cnt2 !== 4'd8 || full2 !== 1'b1) begin
      errors++; $display("FAIL sat_cnt got %0d/%b exp 8/1", cnt1, full1);
    end
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 3'd5);
    checks++;
    if (v1 !== 1'b1 || {re1, im1} !== 32'hA5A5_5A5A) begin
      errors++; $display("FAIL sat_overwrite got %b/%h exp 1/a5a55a5a", v1, {re1, im1});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      tick($urandom_range(11) == 0, $urandom_range(1) == 1, $urandom_range(2) != 0,
           3'($urandom), 16'($urandom), 16'($urandom), $urandom_range(1) == 1, 3'($urandom));
      checks++;
      if ({v1, re1, im1} !== exp_r1 || {v2, re2, im2} !== exp_r2) begin
        errors++; $display("FAIL rand_rd k=%0d got %h %h exp %h %h", k, {v1, re1, im1}, {v2, re2, im2}, exp_r1, exp_r2);
      end
      checks++;
      if ({bank1, cnt1, full1} !== exp_st || {bank2, cnt2, full2} !== exp_st) begin
        errors++; $display("FAIL rand_state k=%0d got %b %b exp %b", k, {bank1, cnt1, full1}, {bank2, cnt2, full2}, exp_st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_bitrev();
    test_lat2();
    test_swap_collision();
    test_reset_inflight();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
